uctl_aon_rmt_wkup: RTL and testbench

UCTL_AON_RMT_WKUP -- requirements
Module: uctl_aon_rmt_wkup

---
 rtl/uctl_aon_rmt_wkup.sv | 137 +++++++++++++
 tb/tb_uctl_aon_rmt_wkup.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uctl_aon_rmt_wkup.sv
// rtl/uctl_aon_rmt_wkup.sv - always-on USB remote-wakeup sequencer (wait bus idle, drive K, report)
module uctl_aon_rmt_wkup #(
    parameter int CNTR_WD = 16
) (
    input  logic               aon_clk,
    input  logic               aon_rst_n,
    input  logic               sw_rst,
    input  logic               power_down,
    input  logic               rmt_wkup_en,
    input  logic               wkup_req,
    input  logic [1:0]         line_state,
    input  logic [CNTR_WD-1:0] idle_cnt,
    input  logic [CNTR_WD-1:0] k_cnt,
    output logic               drive_k,
    output logic               wkup_busy,
    output logic               wkup_done,
    output logic               wkup_abort,
    output logic               wkup_rej
);

    typedef enum logic [1:0] {IDLE, WAIT_IDLE, DRIVE_K, DONE} state_t;

    localparam logic [1:0]         LINE_J = 2'b10;
    localparam logic [1:0]         LINE_K = 2'b01;
    localparam logic [CNTR_WD-1:0] ONE    = {{(CNTR_WD-1){1'b0}}, 1'b1};

    state_t             state, state_nxt;
    logic [CNTR_WD-1:0] cnt, cnt_nxt, cnt_inc;
    logic [CNTR_WD-1:0] idle_tgt, k_tgt;
    logic               abort_q, abort_nxt, rej_q, rej_nxt;
    logic               pd_s1, pd_s2, req_s1, req_s2, req_d3;
    logic [1:0]         ln_s1, ln_s2;
    logic               req_rise;

    always_ff @(posedge aon_clk or negedge aon_rst_n) begin
        if (!aon_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            abort_q <= 1'b0;
            rej_q   <= 1'b0;
            pd_s1   <= 1'b0;
            pd_s2   <= 1'b0;
            req_s1  <= 1'b0;
            req_s2  <= 1'b0;
            req_d3  <= 1'b0;
            ln_s1   <= 2'b00;
            ln_s2   <= 2'b00;
        end else if (sw_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            abort_q <= 1'b0;
            rej_q   <= 1'b0;
            pd_s1   <= 1'b0;
            pd_s2   <= 1'b0;
            req_s1  <= 1'b0;
            req_s2  <= 1'b0;
            req_d3  <= 1'b0;
            ln_s1   <= 2'b00;
            ln_s2   <= 2'b00;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            abort_q <= abort_nxt;
            rej_q   <= rej_nxt;
            pd_s1   <= power_down;
            pd_s2   <= pd_s1;
            req_s1  <= wkup_req;
            req_s2  <= req_s1;
            req_d3  <= req_s2;
            ln_s1   <= line_state;
            ln_s2   <= ln_s1;
        end
    end

    // A programmed count of zero still means one cycle.
    assign idle_tgt = (idle_cnt == '0) ? ONE : idle_cnt;
    assign k_tgt    = (k_cnt == '0) ? ONE : k_cnt;
    assign cnt_inc  = (&cnt) ? cnt : cnt + ONE;
    assign req_rise = req_s2 & ~req_d3;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        abort_nxt = 1'b0;
        rej_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (req_rise) begin
                    if (pd_s2 && rmt_wkup_en) begin
                        state_nxt = WAIT_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        rej_nxt = 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                if (!pd_s2 || ln_s2 == LINE_K) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    abort_nxt = 1'b1;
                end else if (ln_s2 == LINE_J) begin
                    if (cnt_inc == idle_tgt) begin
                        state_nxt = DRIVE_K;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end else begin
                    cnt_nxt = '0;
                end
            end
            DRIVE_K: begin
                if (cnt_inc == k_tgt) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign drive_k    = (state == DRIVE_K);
    assign wkup_busy  = (state != IDLE);
    assign wkup_done  = (state == DONE);
    assign wkup_abort = abort_q;
    assign wkup_rej   = rej_q;

endmodule

// File: tb/tb_uctl_aon_rmt_wkup.sv
// tb/tb_uctl_aon_rmt_wkup.sv - randomized and directed bench for uctl_aon_rmt_wkup
module tb_uctl_aon_rmt_wkup;

    localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LSE0 = 2'b00, LSE1 = 2'b11;

    logic        aon_clk = 1'b0;
    logic        aon_rst_n, sw_rst, power_down, rmt_wkup_en, wkup_req;
    logic [1:0]  line_state;
    logic [15:0] idle_cnt, k_cnt;
    logic        drive_k, wkup_busy, wkup_done, wkup_abort, wkup_rej;

    int vectors = 0;
    int errors  = 0;

    logic [1:0] seq_ln [0:255];
    logic       seq_pd [0:255];
    int         seq_len;
    logic       pd0;
    int         rst_edge;
    int         win;
    int         drv_start;
    logic       exp_drive [0:511];
    logic       exp_busy  [0:511];
    logic       exp_done  [0:511];
    logic       exp_abort [0:511];
    logic       exp_rej   [0:511];

    uctl_aon_rmt_wkup #(.CNTR_WD(16)) dut (
        .aon_clk(aon_clk), .aon_rst_n(aon_rst_n), .sw_rst(sw_rst),
        .power_down(power_down), .rmt_wkup_en(rmt_wkup_en), .wkup_req(wkup_req),
        .line_state(line_state), .idle_cnt(idle_cnt), .k_cnt(k_cnt),
        .drive_k(drive_k), .wkup_busy(wkup_busy), .wkup_done(wkup_done),
        .wkup_abort(wkup_abort), .wkup_rej(wkup_rej)
    );

    always #5 aon_clk = ~aon_clk;

    function automatic logic [4:0] obs();
        return {drive_k, wkup_busy, wkup_done, wkup_abort, wkup_rej};
    endfunction

    function automatic logic [4:0] expv(input int e);
        return {exp_drive[e], exp_busy[e], exp_done[e], exp_abort[e], exp_rej[e]};
    endfunction

    function automatic void push(input logic [1:0] ln, input int n);
        for (int i = 0; i < n; i++) begin
            seq_ln[seq_len] = ln;
            seq_pd[seq_len] = 1'b1;
            seq_len++;
        end
    endfunction

    // Edge 0 is the first edge that sees wkup_req high. Synchronised inputs
    // lag two edges, so the request is acted on at edge 2 and the bus-idle
    // check at edge 3+i looks at the i-th sequence entry.
    function automatic void build_expect();
        int run, e, i, kk, need, stop;
        logic p;
        logic [1:0] l;
        for (int x = 0; x < 512; x++) begin
            exp_drive[x] = 0; exp_busy[x] = 0; exp_done[x] = 0;
            exp_abort[x] = 0; exp_rej[x] = 0;
        end
        drv_start = -1;
        if (!(pd0 && rmt_wkup_en)) begin
            exp_rej[2] = 1;
            win = 8;
            return;
        end
        need = (idle_cnt == 0) ? 1 : int'(idle_cnt);
        kk   = (k_cnt == 0) ? 1 : int'(k_cnt);
        run = 0; e = 3; i = 0; stop = -1;
        while (stop < 0) begin
            p = (i < seq_len) ? seq_pd[i] : seq_pd[seq_len-1];
            l = (i < seq_len) ? seq_ln[i] : LJ;
            if (!p || l == LK) begin
                exp_abort[e] = 1;
                stop = e - 1;
            end else if (l == LJ) begin
                run++;
                if (run == need) begin
                    drv_start = e;
                    for (int d = 0; d < kk; d++) exp_drive[e+d] = 1;
                    exp_done[e+kk] = 1;
                    stop = e + kk;
                end
            end else begin
                run = 0;
            end
            e++; i++;
        end
        for (int x = 2; x <= stop; x++) exp_busy[x] = 1;
        win = stop + 6;
    endfunction

    task automatic prep(input logic pd, input logic en, input int idl, input int kc);
        @(negedge aon_clk);
        pd0 = pd; rmt_wkup_en = en; idle_cnt = 16'(idl); k_cnt = 16'(kc);
        power_down = pd; wkup_req = 0; line_state = LJ; sw_rst = 0;
        rst_edge = -1; seq_len = 0;
        repeat (5) @(negedge aon_clk);
    endtask

    task automatic step(input int e);
        @(negedge aon_clk);
        if (e == 0) begin
            power_down = pd0; line_state = LJ;
        end else if (e - 1 < seq_len) begin
            power_down = seq_pd[e-1]; line_state = seq_ln[e-1];
        end else begin
            line_state = LJ;
        end
        wkup_req = (rst_edge < 0 || e < rst_edge);
        sw_rst   = (e == rst_edge);
        @(posedge aon_clk); #1;
    endtask

    task automatic test_reset();
        aon_rst_n = 0; sw_rst = 0; power_down = 1; rmt_wkup_en = 1; wkup_req = 1;
        line_state = LJ; idle_cnt = 1; k_cnt = 1;
        repeat (3) @(posedge aon_clk);
        #1;
        vectors++;
        if (obs() !== 5'b0) begin
            errors++; $display("FAIL reset_state got=%b exp=%b", obs(), 5'b0);
        end
        @(negedge aon_clk); wkup_req = 0; aon_rst_n = 1;
        repeat (4) @(posedge aon_clk);
        #1;
        vectors++;
        if (obs() !== 5'b0) begin
            errors++; $display("FAIL post_reset_idle got=%b exp=%b", obs(), 5'b0);
        end
    endtask

    task automatic test_normal_wake();
        prep(1, 1, 10, 20);
        push(LJ, 40);
        build_expect();
        for (int e = 0; e <= win; e++) begin
            step(e); vectors++;
            if (obs() !== expv(e)) begin
                errors++; $display("FAIL normal_wake edge=%0d got=%b exp=%b", e, obs(), expv(e));
            end
        end
    endtask

    task automatic test_reject();
        for (int t = 0; t < 2; t++) begin
            prep(t == 1, t == 1 ? 1'b0 : 1'b1, 4, 4);
            push(LJ, 10);
            build_expect();
            for (int e = 0; e <= win; e++) begin
                step(e); vectors++;
                if (obs() !== expv(e)) begin
                    errors++; $display("FAIL reject%0d edge=%0d got=%b exp=%b", t, e, obs(), expv(e));
                end
            end
        end
    endtask

    task automatic test_host_resume();
        prep(1, 1, 10, 5);
        push(LJ, 2); push(LK, 3); push(LJ, 20);
        build_expect();
        for (int e = 0; e <= win; e++) begin
            step(e); vectors++;
            if (obs() !== expv(e)) begin
                errors++; $display("FAIL host_resume edge=%0d got=%b exp=%b", e, obs(), expv(e));
            end
        end
    endtask

    task automatic test_idle_restart();
        prep(1, 1, 8, 4);
        push(LJ, 5); push(LSE0, 1); push(LJ, 8); push(LSE1, 2); push(LJ, 10);
        build_expect();
        for (int e = 0; e <= win; e++) begin
            step(e); vectors++;
            if (obs() !== expv(e)) begin
                errors++; $display("FAIL idle_restart edge=%0d got=%b exp=%b", e, obs(), expv(e));
            end
        end
    endtask

    task automatic test_boundary();
        prep(1, 1, 0, 0);
        push(LJ, 4);
        build_expect();
        win = win + 6;
        for (int e = 0; e <= win; e++) begin
            step(e); vectors++;
            if (obs() !== expv(e)) begin
                errors++; $display("FAIL boundary edge=%0d got=%b exp=%b", e, obs(), expv(e));
            end
        end
    endtask

    task automatic test_sw_rst_mid_drive();
        prep(1, 1, 3, 20);
        push(LJ, 30);
        build_expect();
        rst_edge = drv_start + 5;
        for (int x = rst_edge; x < 512; x++) begin
            exp_drive[x] = 0; exp_busy[x] = 0; exp_done[x] = 0;
        end
        win = rst_edge + 25;
        for (int e = 0; e <= win; e++) begin
            step(e); vectors++;
            if (obs() !== expv(e)) begin
                errors++; $display("FAIL sw_rst_mid_drive edge=%0d got=%b exp=%b", e, obs(), expv(e));
            end
        end
    endtask

    task automatic test_async_reset();
        prep(1, 1, 2, 10);
        push(LJ, 20);
        build_expect();
        for (int e = 0; e <= drv_start + 3; e++) begin
            step(e); vectors++;
            if (obs() !== expv(e)) begin
                errors++; $display("FAIL async_pre edge=%0d got=%b exp=%b", e, obs(), expv(e));
            end
        end
        #2 aon_rst_n = 0;
        #1 vectors++;
        if (obs() !== 5'b0) begin
            errors++; $display("FAIL async_reset got=%b exp=%b", obs(), 5'b0);
        end
        @(negedge aon_clk); wkup_req = 0; aon_rst_n = 1;
        repeat (15) begin
            @(posedge aon_clk); #1 vectors++;
            if (obs() !== 5'b0) begin
                errors++; $display("FAIL async_post got=%b exp=%b", obs(), 5'b0);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] ln;
        int r, drop;
        for (int it = 0; it < 25; it++) begin
            prep($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 6), $urandom_range(0, 8));
            r = $urandom_range(4, 30);
            for (int i = 0; i < r; i++) begin
                case ($urandom_range(0, 19))
                    0, 1:    ln = LSE0;
                    2:       ln = LSE1;
                    3:       ln = LK;
                    default: ln = LJ;
                endcase
                push(ln, 1);
            end
            push(LJ, 8);
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, seq_len - 1) : -1;
            if (drop >= 0)
                for (int i = drop; i < seq_len; i++) seq_pd[i] = 1'b0;
            build_expect();
            for (int e = 0; e <= win; e++) begin
                step(e); vectors++;
                if (obs() !== expv(e)) begin
                    errors++;
                    $display("FAIL random it=%0d edge=%0d got=%b exp=%b", it, e, obs(), expv(e));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_wake();
        test_reject();
        test_host_resume();
        test_idle_restart();
        test_boundary();
        test_sw_rst_mid_drive();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
